// File: rtl/filter_frame_sequencer_if.sv
// Bus between the 3x3 filter frame sequencer and its surroundings.
//
// Handshake semantics: a pixel moves from the source into the sequencer on a
// cycle where pix_valid and pix_ready are both high. pix_ready never depends
// on pix_valid. out_ready is a stall input: while it is low no beat happens,
// nothing advances and pix_ready is held low. A beat (lb_wr_en) is one step
// of the per-frame pipeline: an accepted pixel in RUN, or a drain step in DRAIN.
//
// Signals:
//   start, cfg_width, cfg_height, cfg_frames  run control and configuration
//   pix_valid / pix_ready                      pixel handshake
//   out_ready                                  downstream stall
//   lb_wr_en, lb_flush, lb_wr_line             line buffer control
//   win_valid, cen_col, cen_row, brd_*         window-centre status
//   frame_done, busy, done, cfg_err            run status
//   state_dbg                                  raw FSM state for observation
interface filter_frame_sequencer_if #(
    parameter int DIM_W = 16,
    parameter int FRM_W = 32
);
    logic             start;
    logic [DIM_W-1:0] cfg_width;
    logic [DIM_W-1:0] cfg_height;
    logic [FRM_W-1:0] cfg_frames;
    logic             pix_valid;
    logic             pix_ready;
    logic             out_ready;
    logic             lb_wr_en;
    logic             lb_flush;
    logic [1:0]       lb_wr_line;
    logic             win_valid;
    logic [DIM_W-1:0] cen_col;
    logic [DIM_W-1:0] cen_row;
    logic             brd_top;
    logic             brd_bot;
    logic             brd_left;
    logic             brd_right;
    logic             frame_done;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [1:0]       state_dbg;

    modport master (
        output start, cfg_width, cfg_height, cfg_frames, pix_valid, out_ready,
        input  pix_ready, lb_wr_en, lb_flush, lb_wr_line, win_valid, cen_col, cen_row,
               brd_top, brd_bot, brd_left, brd_right, frame_done, busy, done, cfg_err,
               state_dbg
    );

    modport slave (
        input  start, cfg_width, cfg_height, cfg_frames, pix_valid, out_ready,
        output pix_ready, lb_wr_en, lb_flush, lb_wr_line, win_valid, cen_col, cen_row,
               brd_top, brd_bot, brd_left, brd_right, frame_done, busy, done, cfg_err,
               state_dbg
    );
endinterface

// File: rtl/filter_frame_sequencer.sv
// Frame-level control FSM for a 3x3 streaming filter datapath. Accepts W*H
// pixels per frame, then issues W+1 drain beats so the last line's windows
// emerge; flags window-centre validity and image borders; repeats for F frames.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   bus_if slave side of filter_frame_sequencer_if (config, pixel handshake,
//          line-buffer control, window status, run status, state_dbg)
module filter_frame_sequencer #(
    parameter int DIM_W = 16,
    parameter int FRM_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    filter_frame_sequencer_if.slave bus_if
);
    localparam int KW = 2 * DIM_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [DIM_W-1:0]   w_q;
    logic [DIM_W-1:0]   h_q;
    logic [2*DIM_W-1:0] wh_q;
    logic [FRM_W-1:0]   frames_left_q;
    logic [KW-1:0]      k_q;
    logic [DIM_W-1:0]   in_col_q;
    logic [1:0]         line_q;
    logic [DIM_W-1:0]   cen_col_q;
    logic [DIM_W-1:0]   cen_row_q;
    logic               frame_done_q;
    logic               done_q;
    logic               cfg_err_q;

    logic          in_run;
    logic          in_drain;
    logic          beat;
    logic          col_last;
    logic          win;
    logic          last_run_beat;
    logic          last_drain_beat;
    logic          cfg_bad;
    logic [KW-1:0] w_ext;
    logic [KW-1:0] wh_ext;

    assign in_run   = (state_q == S_RUN);
    assign in_drain = (state_q == S_DRAIN);
    assign beat     = bus_if.out_ready & ((in_run & bus_if.pix_valid) | in_drain);
    assign col_last = (in_col_q == w_q - DIM_W'(1));

    assign w_ext  = {{(KW-DIM_W){1'b0}}, w_q};
    assign wh_ext = {1'b0, wh_q};

    // Windows lag the input by one line plus one pixel, so the first centre
    // becomes available at k = W+1; the drain beats flush the tail.
    assign win             = beat & (k_q >= w_ext + KW'(1));
    assign last_run_beat   = in_run & (k_q == wh_ext - KW'(1));
    assign last_drain_beat = in_drain & (k_q == wh_ext + w_ext);

    assign cfg_bad = (bus_if.cfg_width < DIM_W'(3)) | (bus_if.cfg_height < DIM_W'(3)) |
                     (bus_if.cfg_frames == '0);

    assign bus_if.pix_ready  = in_run & bus_if.out_ready;
    assign bus_if.lb_wr_en   = beat;
    assign bus_if.lb_flush   = beat & in_drain;
    assign bus_if.lb_wr_line = line_q;
    assign bus_if.win_valid  = win;
    assign bus_if.cen_col    = cen_col_q;
    assign bus_if.cen_row    = cen_row_q;
    assign bus_if.brd_top    = win & (cen_row_q == '0);
    assign bus_if.brd_bot    = win & (cen_row_q == h_q - DIM_W'(1));
    assign bus_if.brd_left   = win & (cen_col_q == '0);
    assign bus_if.brd_right  = win & (cen_col_q == w_q - DIM_W'(1));
    assign bus_if.frame_done = frame_done_q;
    assign bus_if.busy       = in_run | in_drain;
    assign bus_if.done       = done_q;
    assign bus_if.cfg_err    = cfg_err_q;
    assign bus_if.state_dbg  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            w_q           <= '0;
            h_q           <= '0;
            wh_q          <= '0;
            frames_left_q <= '0;
            k_q           <= '0;
            in_col_q      <= '0;
            line_q        <= '0;
            cen_col_q     <= '0;
            cen_row_q     <= '0;
            frame_done_q  <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus_if.start) begin
                        w_q           <= bus_if.cfg_width;
                        h_q           <= bus_if.cfg_height;
                        wh_q          <= {{DIM_W{1'b0}}, bus_if.cfg_width} *
                                         {{DIM_W{1'b0}}, bus_if.cfg_height};
                        frames_left_q <= bus_if.cfg_frames;
                        k_q           <= '0;
                        in_col_q      <= '0;
                        line_q        <= '0;
                        cen_col_q     <= '0;
                        cen_row_q     <= '0;
                        if (cfg_bad) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            cfg_err_q <= 1'b1;
                        end else begin
                            state_q   <= S_RUN;
                            done_q    <= 1'b0;
                            cfg_err_q <= 1'b0;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (beat) begin
                        if (last_drain_beat) begin
                            // Frame boundary: every per-frame counter restarts.
                            frame_done_q  <= 1'b1;
                            frames_left_q <= frames_left_q - FRM_W'(1);
                            k_q           <= '0;
                            in_col_q      <= '0;
                            line_q        <= '0;
                            cen_col_q     <= '0;
                            cen_row_q     <= '0;
                            if (frames_left_q == FRM_W'(1)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                            end
                        end else begin
                            k_q <= k_q + KW'(1);
                            if (col_last) begin
                                in_col_q <= '0;
                                line_q   <= (line_q == 2'd2) ? 2'd0 : line_q + 2'd1;
                            end else begin
                                in_col_q <= in_col_q + DIM_W'(1);
                            end
                            if (win) begin
                                if (cen_col_q == w_q - DIM_W'(1)) begin
                                    cen_col_q <= '0;
                                    cen_row_q <= cen_row_q + DIM_W'(1);
                                end else begin
                                    cen_col_q <= cen_col_q + DIM_W'(1);
                                end
                            end
                            if (last_run_beat) begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filter_frame_sequencer.sv
module tb_filter_frame_sequencer;
    localparam int DIM_W = 16;
    localparam int FRM_W = 32;
    localparam int SW    = 36;
    localparam int OW    = 46;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    filter_frame_sequencer_if #(.DIM_W(DIM_W), .FRM_W(FRM_W)) bus();

    filter_frame_sequencer #(.DIM_W(DIM_W), .FRM_W(FRM_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    // Scoreboard: expected windows {top,bot,left,right,row,col} in order.
    logic [SW-1:0] exp_q[$];

    int checks   = 0;
    int failures = 0;
    int win_cnt  = 0;
    int fd_cnt   = 0;
    int flush_cnt = 0;
    int acc_cnt  = 0;
    int cur_w    = 4;
    int cur_h    = 3;
    int tb_k     = 0;
    bit fd_exp   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] all_outs();
        return {bus.pix_ready, bus.lb_wr_en, bus.lb_flush, bus.lb_wr_line, bus.win_valid,
                bus.cen_col, bus.cen_row, bus.brd_top, bus.brd_bot, bus.brd_left,
                bus.brd_right, bus.frame_done, bus.busy, bus.done, bus.cfg_err};
    endfunction

    // ---------------- monitor ----------------
    int            wh_m;
    bit            eb;
    bit            epr;
    logic [SW-1:0] got_w;
    logic [SW-1:0] exp_w;

    always @(negedge clk) begin
        if (rst) begin
            tb_k   = 0;
            fd_exp = 1'b0;
        end else begin
            wh_m = cur_w * cur_h;
            check("frame_done", bus.frame_done, fd_exp);
            if (bus.frame_done) fd_cnt++;
            fd_exp = 1'b0;
            if (!bus.busy) tb_k = 0;
            epr = bus.busy && bus.out_ready && (tb_k < wh_m);
            eb  = bus.busy && bus.out_ready && ((tb_k < wh_m) ? bus.pix_valid : 1'b1);
            check("pix_ready", bus.pix_ready, epr);
            check("lb_wr_en", bus.lb_wr_en, eb);
            if (bus.pix_valid && bus.pix_ready) acc_cnt++;
            if (bus.lb_flush) flush_cnt++;
            got_w = {bus.brd_top, bus.brd_bot, bus.brd_left, bus.brd_right, bus.cen_row, bus.cen_col};
            if (!bus.win_valid) begin
                check("brd_idle", got_w[SW-1:SW-4], 4'b0);
            end else begin
                win_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL window_unexpected actual=%0h expected=none", got_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("window", got_w, exp_w);
                end
            end
            if (eb) begin
                check("lb_flush", bus.lb_flush, tb_k >= wh_m);
                check("lb_wr_line", bus.lb_wr_line, (tb_k / cur_w) % 3);
                check("win_valid", bus.win_valid, tb_k >= cur_w + 1);
                if (tb_k == wh_m + cur_w) begin
                    tb_k   = 0;
                    fd_exp = 1'b1;
                end else begin
                    tb_k++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_windows(input int w, input int h, input int f);
        logic [15:0] rr;
        logic [15:0] cc;
        for (int fr = 0; fr < f; fr++)
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++) begin
                    rr = 16'(r);
                    cc = 16'(c);
                    exp_q.push_back({r == 0, r == h - 1, c == 0, c == w - 1, rr, cc});
                end
    endtask

    task automatic issue_start(input int w, input int h, input int f);
        @(posedge clk); #1;
        cur_w = w;
        cur_h = h;
        bus.cfg_width  = 16'(w);
        bus.cfg_height = 16'(h);
        bus.cfg_frames = 32'(f);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_and_wait(input int w, input int h, input int f, input bit gaps, input bit poke);
        int fd0;
        int w0;
        int fl0;
        int ac0;
        int cyc;
        fd0 = fd_cnt; w0 = win_cnt; fl0 = flush_cnt; ac0 = acc_cnt; cyc = 0;
        push_windows(w, h, f);
        issue_start(w, h, f);
        check("busy_after_start", bus.busy, 1'b1);
        check("done_cleared", bus.done, 1'b0);
        check("cfg_err_cleared", bus.cfg_err, 1'b0);
        while (!bus.done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (gaps) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.pix_valid = ($urandom_range(0, 2) != 0);
            end
            if (poke) begin
                if (cyc == 5 || cyc == 12) begin
                    bus.cfg_width  = 16'd5;
                    bus.cfg_height = 16'd5;
                    bus.cfg_frames = 32'd2;
                    bus.start = 1'b1;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        bus.pix_valid = 1'b1;
        if (cyc >= 3000) begin
            checks++;
            failures++;
            $display("FAIL run_timeout actual=%0d expected=<3000", cyc);
        end
        @(negedge clk);
        @(negedge clk);
        check("frame_done_count", fd_cnt - fd0, f);
        check("window_count", win_cnt - w0, w * h * f);
        check("flush_count", flush_cnt - fl0, (w + 1) * f);
        check("accept_count", acc_cnt - ac0, w * h * f);
        check("busy_end", bus.busy, 1'b0);
        check("done_end", bus.done, 1'b1);
        check("cfg_err_end", bus.cfg_err, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.cfg_width = '0;
        bus.cfg_height = '0;
        bus.cfg_frames = '0;
        bus.pix_valid = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), '0);
        check("reset_state", bus.state_dbg, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic frame with start pulses that must be ignored mid-run.
        run_and_wait(4, 3, 1, 1'b0, 1'b1);

        // Multi-frame run with random stalls and source gaps.
        run_and_wait(3, 3, 3, 1'b1, 1'b0);

        // Illegal width: straight to DONE with cfg_err, no beats.
        issue_start(2, 5, 1);
        check("bad_cfg_done", bus.done, 1'b1);
        check("bad_cfg_err", bus.cfg_err, 1'b1);
        check("bad_cfg_state", bus.state_dbg, 2'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bad_cfg_no_beat", bus.lb_wr_en, 1'b0);
        end
        run_and_wait(3, 3, 1, 1'b0, 1'b0);

        // Reset in the middle of a frame, then a clean run.
        push_windows(8, 4, 2);
        issue_start(8, 4, 2);
        cyc = 0;
        while (tb_k != 10 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 200) begin
            checks++;
            failures++;
            $display("FAIL reach_k10 actual=%0d expected=10", tb_k);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midframe_reset_outputs", all_outs(), '0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run_and_wait(8, 4, 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
